// File: rtl/flick_conditioner.sv
// Push-button conditioner: synchroniser, counter-based debounce FSM, clean level and press pulse.
// Define FLICK_CONDITIONER_AUTO_REPEAT_EN to make flick_pulse auto-repeat while the button is held.
module flick_conditioner #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = 8,
  parameter int unsigned HOLD_CYCLES     = 200,
  parameter int unsigned REPEAT_CYCLES   = 50
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_raw,
  output logic       flick,
  output logic       flick_pulse,
  output logic       btn_sync,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    StIdle        = 2'b00,
    StPressWait   = 2'b01,
    StPressed     = 2'b10,
    StReleaseWait = 2'b11
  } state_e;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
    $error("flick_conditioner: SYNC_STAGES must be in 2..4");
  end

  if (DEBOUNCE_CYCLES < 2 ||
      longint'(DEBOUNCE_CYCLES) >= (longint'(1) << CNT_W)) begin : g_bad_debounce
    $error("flick_conditioner: DEBOUNCE_CYCLES must be in 2..(2**CNT_W - 1)");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  state_e                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   flick_q;
  logic                   flick_pulse_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
    end
  end

  assign btn_sync = sync_q[SYNC_STAGES-1];

`ifdef FLICK_CONDITIONER_AUTO_REPEAT_EN
  localparam int unsigned RepMax = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned RepW   = $clog2(RepMax + 1);

  if (HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_repeat
    $error("flick_conditioner: HOLD_CYCLES and REPEAT_CYCLES must be at least 1");
  end

  logic [RepW-1:0] rep_cnt_q;
  logic            rep_hold_q;  // set once the initial hold delay has elapsed
  logic [RepW-1:0] rep_next;
  logic            rep_fire;

  assign rep_next = rep_cnt_q + RepW'(1);
  assign rep_fire = rep_hold_q ? (rep_next == RepW'(REPEAT_CYCLES))
                               : (rep_next == RepW'(HOLD_CYCLES));
`else
  if (HOLD_CYCLES == 0 && REPEAT_CYCLES == 0) begin : g_repeat_timing_unused
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      flick_q       <= 1'b0;
      flick_pulse_q <= 1'b0;
`ifdef FLICK_CONDITIONER_AUTO_REPEAT_EN
      rep_cnt_q     <= '0;
      rep_hold_q    <= 1'b0;
`endif
    end else begin
      flick_pulse_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (btn_sync) begin
            state_q <= StPressWait;
            cnt_q   <= CntOne;
          end
        end
        StPressWait: begin
          if (!btn_sync) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end else if (cnt_q == CntLast) begin
            state_q       <= StPressed;
            cnt_q         <= '0;
            flick_q       <= 1'b1;
            flick_pulse_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        StPressed: begin
          if (!btn_sync) begin
            state_q <= StReleaseWait;
            cnt_q   <= CntOne;
          end
        end
        StReleaseWait: begin
          // A bounce back high returns to PRESSED silently; flick never dropped.
          if (btn_sync) begin
            state_q <= StPressed;
            cnt_q   <= '0;
          end else if (cnt_q == CntLast) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            flick_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
      endcase
`ifdef FLICK_CONDITIONER_AUTO_REPEAT_EN
      if (state_q == StPressed && btn_sync) begin
        if (rep_fire) begin
          rep_cnt_q     <= '0;
          rep_hold_q    <= 1'b1;
          flick_pulse_q <= 1'b1;
        end else begin
          rep_cnt_q <= rep_next;
        end
      end else if (state_q == StIdle) begin
        rep_cnt_q  <= '0;
        rep_hold_q <= 1'b0;
      end
`endif
    end
  end

  assign flick       = flick_q;
  assign flick_pulse = flick_pulse_q;
  assign state_o     = state_q;

endmodule

// File: doc/flick_conditioner.md
Name: flick_conditioner

Overview:
- Input-conditioning stage directly upstream of the bound-flasher controller.
- Takes the raw, asynchronous, bouncing `flick` push-button and synchronises it into `clk`.
- Debounces it with a counter-based FSM.
- Outputs:
  - a clean level `flick`, wired straight to the flasher's `flick` input;
  - a one-cycle press pulse `flick_pulse` for event-driven consumers.

Parameters:
- SYNC_STAGES, 2: number of synchroniser flops on `btn_raw`; legal range 2..4.
- DEBOUNCE_CYCLES, 16: consecutive stable samples needed to accept a level change; legal range 2..(2^CNT_W - 1).
- CNT_W, 8: width of the debounce counter.
- HOLD_CYCLES, 200: PRESSED cycles before auto-repeat starts (optional feature only).
- REPEAT_CYCLES, 50: auto-repeat period in cycles (optional feature only).

Ports:
- clk  input  1  system clock; all state on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- btn_raw  input  1  raw button, asynchronous to clk, may bounce.
- flick  output  1  debounced level; registered.
- flick_pulse  output  1  one-cycle pulse on each accepted press; registered.
- btn_sync  output  1  last synchroniser stage; debug/observe.
- state_o  output  2  current FSM state encoding; debug.

Behaviour:

Reset:
- reset_n=0 forces, asynchronously:
  - all synchroniser flops = 0;
  - counter = 0;
  - state = IDLE;
  - flick = 0, flick_pulse = 0, btn_sync = 0.
- Reset asserted mid-press or mid-debounce aborts immediately; no pulse is emitted.
- After release of reset, state = IDLE even if btn_raw is high. A press held through reset is accepted through the normal debounce path.

Synchroniser:
- Plain SYNC_STAGES-flop shift chain. btn_sync = last stage.
- No logic between stages.

States (2-bit encoding):
- IDLE=00: flick=0.
  - btn_sync=1 → PRESS_WAIT, counter=1.
- PRESS_WAIT=01: flick=0.
  - btn_sync=1 and counter==DEBOUNCE_CYCLES-1 → PRESSED.
  - btn_sync=1 otherwise: counter+1.
  - btn_sync=0 → IDLE, counter=0. A glitch is rejected with no output change.
- PRESSED=10: flick=1.
  - btn_sync=0 → RELEASE_WAIT, counter=1.
- RELEASE_WAIT=11: flick=1.
  - btn_sync=0 and counter==DEBOUNCE_CYCLES-1 → IDLE, counter=0.
  - btn_sync=0 otherwise: counter+1.
  - btn_sync=1 → PRESSED, counter=0.

Outputs and timing:
- flick is a registered decode of state: it is 1 in PRESSED or RELEASE_WAIT.
- flick_pulse=1 for exactly the single cycle in which the state first becomes PRESSED from PRESS_WAIT. A return from RELEASE_WAIT to PRESSED produces no pulse.
- Latency, for btn_raw stable-high from sampling edge 0 while in IDLE:
  - btn_sync rises after edge SYNC_STAGES-1;
  - flick rises after edge SYNC_STAGES+DEBOUNCE_CYCLES-1.
- Release latency is identical.
- Counter never wraps: it is only compared up to DEBOUNCE_CYCLES-1 and is cleared on every state change.
- Counter is CNT_W bits. DEBOUNCE_CYCLES ≥ 2^CNT_W is illegal; the implementation must flag it with an elaboration-time error.
- Bounce shorter than DEBOUNCE_CYCLES cycles never changes flick.
- Minimum flick high time = DEBOUNCE_CYCLES cycles.

Optional Feature:
- Macro: FLICK_CONDITIONER_AUTO_REPEAT_EN.
- When defined:
  - a repeat counter runs while state==PRESSED;
  - after HOLD_CYCLES cycles in PRESSED, flick_pulse fires one cycle;
  - it then fires again every REPEAT_CYCLES cycles while PRESSED continues;
  - leaving PRESSED, or reset, clears the repeat counter;
  - RELEASE_WAIT freezes the repeat counter, and a bounce back to PRESSED resumes the count.
  - flick level is unaffected.
- When not defined:
  - no repeat logic exists;
  - flick_pulse fires only once per accepted press;
  - HOLD_CYCLES and REPEAT_CYCLES are ignored.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=4):
- Reset with btn_raw=1, release reset at edge 0, hold high → flick, flick_pulse, btn_sync = 0 during reset; btn_sync=1 after edge 1; flick=1 and flick_pulse=1 after edge 5; flick_pulse=0 after edge 6.
- Glitch: btn_raw high for 3 cycles, then low → state goes 00→01→00; flick stays 0; flick_pulse never 1.
- Bouncy press: 1,0,1,0, then stable 1 → exactly one flick_pulse; flick rises 4 cycles after btn_sync becomes stable 1.
- Release bounce: from PRESSED, btn_raw 0 for 2 cycles, 1 for 1 cycle, then stable 0 → flick remains 1 through the bounce, falls 4 cycles after stable btn_sync=0, and no extra pulse is emitted.
- Reset mid-debounce: assert reset_n=0 in PRESS_WAIT with counter=2 → state=00, counter=0, outputs 0 immediately and asynchronously.
- With FLICK_CONDITIONER_AUTO_REPEAT_EN, HOLD_CYCLES=10, REPEAT_CYCLES=5, button held 30 cycles after PRESSED → pulses at PRESSED-entry+0, +10, +15, +20, +25; none after release.
